// File: rtl/cc_top_ctrl_if.sv
// Pin bundle of the cache controller: APB config, INCT AR/R, MEM AR/R and the tag/data SRAM.
// Suffixes are from the controller's side; it takes the slave modport, its surroundings the master.
interface cc_top_ctrl_if;
  logic         psel_i;
  logic         penable_i;
  logic [11:0]  paddr_i;
  logic         pwrite_i;
  logic [31:0]  pwdata_i;
  logic         pready_o;
  logic [31:0]  prdata_o;
  logic         pslverr_o;

  logic [3:0]   inct_arid_i;
  logic [31:0]  inct_araddr_i;
  logic [3:0]   inct_arlen_i;
  logic [2:0]   inct_arsize_i;
  logic [1:0]   inct_arburst_i;
  logic         inct_arvalid_i;
  logic         inct_arready_o;

  logic [3:0]   inct_rid_o;
  logic [63:0]  inct_rdata_o;
  logic [1:0]   inct_rresp_o;
  logic         inct_rlast_o;
  logic         inct_rvalid_o;
  logic         inct_rready_i;

  logic [3:0]   mem_arid_o;
  logic [31:0]  mem_araddr_o;
  logic [3:0]   mem_arlen_o;
  logic [2:0]   mem_arsize_o;
  logic [1:0]   mem_arburst_o;
  logic         mem_arvalid_o;
  logic         mem_arready_i;

  logic [3:0]   mem_rid_i;
  logic [63:0]  mem_rdata_i;
  logic [1:0]   mem_rresp_i;
  logic         mem_rlast_i;
  logic         mem_rvalid_i;
  logic         mem_rready_o;

  logic         rden_o;
  logic [8:0]   raddr_o;
  logic [17:0]  rdata_tag_i;
  logic [511:0] rdata_data_i;
  logic         wren_o;
  logic [8:0]   waddr_o;
  logic [17:0]  wdata_tag_o;
  logic [511:0] wdata_data_o;

  modport slave (
    input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
    output pready_o, prdata_o, pslverr_o,
    input  inct_arid_i, inct_araddr_i, inct_arlen_i, inct_arsize_i, inct_arburst_i, inct_arvalid_i,
    output inct_arready_o,
    output inct_rid_o, inct_rdata_o, inct_rresp_o, inct_rlast_o, inct_rvalid_o,
    input  inct_rready_i,
    output mem_arid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o, mem_arvalid_o,
    input  mem_arready_i,
    input  mem_rid_i, mem_rdata_i, mem_rresp_i, mem_rlast_i, mem_rvalid_i,
    output mem_rready_o,
    output rden_o, raddr_o,
    input  rdata_tag_i, rdata_data_i,
    output wren_o, waddr_o, wdata_tag_o, wdata_data_o
  );

  modport master (
    output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
    input  pready_o, prdata_o, pslverr_o,
    output inct_arid_i, inct_araddr_i, inct_arlen_i, inct_arsize_i, inct_arburst_i, inct_arvalid_i,
    input  inct_arready_o,
    input  inct_rid_o, inct_rdata_o, inct_rresp_o, inct_rlast_o, inct_rvalid_o,
    output inct_rready_i,
    input  mem_arid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o, mem_arvalid_o,
    output mem_arready_i,
    output mem_rid_i, mem_rdata_i, mem_rresp_i, mem_rlast_i, mem_rvalid_i,
    input  mem_rready_o,
    input  rden_o, raddr_o,
    output rdata_tag_i, rdata_data_i,
    input  wren_o, waddr_o, wdata_tag_o, wdata_data_o
  );
endinterface

// File: rtl/cc_top_ctrl.sv
// Direct-mapped read-only cache controller, 512 lines x 64 B, critical-word-first WRAP replies.
// Define CC_PERF_CNT_EN to add hit/miss counters readable over APB at 0x004/0x008.
module cc_top_ctrl #(
  parameter logic [11:0] IP_VER = 12'h000
) (
  input  logic         clk,
  input  logic         rst,
  cc_top_ctrl_if.slave bus
);
  localparam int WORDS  = 8;
  localparam int WORD_W = 64;

  typedef enum logic [2:0] {
    S_IDLE, S_TAG_RD, S_TAG_CMP, S_MISS_AR, S_MISS_R, S_FILL, S_SEND
  } state_e;

  state_e                         state_q, state_d;
  logic [3:0]                     id_q;
  logic [31:0]                    addr_q;
  logic [WORDS-1:0][WORD_W-1:0]   line_q;
  logic [2:0]                     beat_q;

  logic [16:0] tag;
  logic [8:0]  idx;
  logic [2:0]  wsel;
  logic        hit, ar_rdy, ar_hs, r_hs, mr_hs;

  assign tag    = addr_q[31:15];
  assign idx    = addr_q[14:6];
  // Beat j of the reply carries word (offset word + j) mod 8; 3-bit add wraps for free.
  assign wsel   = addr_q[5:3] + beat_q;
  assign hit    = bus.rdata_tag_i[17] && (bus.rdata_tag_i[16:0] == tag);
  assign ar_rdy = (state_q == S_IDLE) && !rst;
  assign ar_hs  = ar_rdy && bus.inct_arvalid_i;
  assign r_hs   = (state_q == S_SEND) && bus.inct_rready_i;
  assign mr_hs  = (state_q == S_MISS_R) && bus.mem_rvalid_i;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.inct_arvalid_i) state_d = S_TAG_RD;
      S_TAG_RD:  state_d = S_TAG_CMP;
      S_TAG_CMP: state_d = hit ? S_SEND : S_MISS_AR;
      S_MISS_AR: if (bus.mem_arready_i) state_d = S_MISS_R;
      S_MISS_R:  if (bus.mem_rvalid_i && bus.mem_rlast_i) state_d = S_FILL;
      S_FILL:    state_d = S_SEND;
      S_SEND:    if (bus.inct_rready_i && beat_q == 3'd7) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q   <= '0;
      addr_q <= '0;
      line_q <= '0;
      beat_q <= '0;
    end else begin
      if (ar_hs) begin
        id_q   <= bus.inct_arid_i;
        addr_q <= bus.inct_araddr_i;
      end
      case (state_q)
        S_TAG_CMP: begin
          beat_q <= '0;
          if (hit) line_q <= bus.rdata_data_i;
        end
        S_MISS_R: if (mr_hs) begin
          line_q[beat_q] <= bus.mem_rdata_i;
          beat_q         <= beat_q + 3'd1;
        end
        S_FILL: beat_q <= '0;
        S_SEND: if (r_hs) beat_q <= beat_q + 3'd1;
        default: ;
      endcase
    end
  end

  // Everything is forced quiet while rst is high, even before the state register has been cleared.
  always_comb begin
    bus.inct_arready_o = ar_rdy;
    bus.inct_rvalid_o  = 1'b0;
    bus.inct_rid_o     = '0;
    bus.inct_rdata_o   = '0;
    bus.inct_rresp_o   = '0;
    bus.inct_rlast_o   = 1'b0;
    bus.mem_arvalid_o  = 1'b0;
    bus.mem_arid_o     = '0;
    bus.mem_araddr_o   = '0;
    bus.mem_arlen_o    = '0;
    bus.mem_arsize_o   = '0;
    bus.mem_arburst_o  = '0;
    bus.mem_rready_o   = 1'b0;
    bus.rden_o         = 1'b0;
    bus.raddr_o        = '0;
    bus.wren_o         = 1'b0;
    bus.waddr_o        = '0;
    bus.wdata_tag_o    = '0;
    bus.wdata_data_o   = '0;
    if (!rst) begin
      case (state_q)
        S_TAG_RD: begin
          bus.rden_o  = 1'b1;
          bus.raddr_o = idx;
        end
        S_MISS_AR: begin
          bus.mem_arvalid_o = 1'b1;
          bus.mem_araddr_o  = {addr_q[31:6], 6'b0};
          bus.mem_arlen_o   = 4'd7;
          bus.mem_arsize_o  = 3'd3;
          bus.mem_arburst_o = 2'd1;
        end
        S_MISS_R: bus.mem_rready_o = 1'b1;
        S_FILL: begin
          bus.wren_o       = 1'b1;
          bus.waddr_o      = idx;
          bus.wdata_tag_o  = {1'b1, tag};
          bus.wdata_data_o = line_q;
        end
        S_SEND: begin
          bus.inct_rvalid_o = 1'b1;
          bus.inct_rid_o    = id_q;
          bus.inct_rdata_o  = line_q[wsel];
          bus.inct_rlast_o  = (beat_q == 3'd7);
        end
        default: ;
      endcase
    end
  end

`ifdef CC_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        cnt_clr;

  assign cnt_clr = bus.psel_i && bus.penable_i && bus.pwrite_i && (bus.paddr_i == 12'h004);

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_TAG_CMP) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
`endif

  // Zero-wait APB: read data is decoded straight from the address during the access.
  assign bus.pready_o  = 1'b1;
  assign bus.pslverr_o = 1'b0;

  always_comb begin
    bus.prdata_o = '0;
    if (!rst && bus.psel_i && !bus.pwrite_i) begin
      case (bus.paddr_i)
        12'h000: bus.prdata_o = {20'h0, IP_VER};
`ifdef CC_PERF_CNT_EN
        12'h004: bus.prdata_o = hit_cnt_q;
        12'h008: bus.prdata_o = miss_cnt_q;
`endif
        default: bus.prdata_o = '0;
      endcase
    end
  end

  // Burst shape is fixed, and the memory's id/resp are not forwarded.
  logic unused_ok;
  assign unused_ok = ^{bus.inct_arlen_i, bus.inct_arsize_i, bus.inct_arburst_i,
                       bus.mem_rid_i, bus.mem_rresp_i, bus.pwdata_i, bus.penable_i};
endmodule

// File: tb/tb_cc_top_ctrl.sv
// Bench for cc_top_ctrl: memory/SRAM models, a line-level cache model and a per-cycle output checker.
module tb_cc_top_ctrl;
`ifdef CC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sram_rst = 1'b1;
  always #5 clk = ~clk;

  cc_top_ctrl_if bus ();
  cc_top_ctrl #(.IP_VER(12'h000)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mw(input logic [31:0] a);
    return {a ^ 32'hC0DE_0000, (a * 32'd2654435761) ^ 32'h1357_9BDF};
  endfunction

  function automatic logic [511:0] line_of(input logic [31:0] b);
    logic [511:0] r;
    for (int k = 0; k < 8; k++) r[64*k +: 64] = mw(b + 32'(8 * k));
    return r;
  endfunction

  // Tag/data SRAM with one-cycle read latency; only its own reset clears the tags.
  logic [17:0]  s_tag [512];
  logic [511:0] s_dat [512];
  always @(posedge clk) begin
    if (sram_rst) begin
      for (int i = 0; i < 512; i++) s_tag[i] <= '0;
      bus.rdata_tag_i  <= '0;
      bus.rdata_data_i <= '0;
    end else begin
      if (bus.rden_o) begin
        bus.rdata_tag_i  <= s_tag[bus.raddr_o];
        bus.rdata_data_i <= s_dat[bus.raddr_o];
      end
      if (bus.wren_o) begin
        s_tag[bus.waddr_o] <= bus.wdata_tag_o;
        s_dat[bus.waddr_o] <= bus.wdata_data_o;
      end
    end
  end

  // Line-level cache model and expectations shared with the checker.
  bit          ref_v   [512];
  logic [16:0] ref_tag [512];
  int          m_hit = 0, m_miss = 0;
  logic [70:0] exp_q [$];
  logic [31:0] exp_line = '0;
  logic [8:0]  exp_idx = '0;
  logic [16:0] exp_tag = '0;
  int          beats_tot = 0, ar_cnt = 0, wr_cnt = 0, rv_rise = 0;
  logic [31:0] last_ar = '0;
  logic [8:0]  last_waddr = '0;
  logic [17:0] last_wtag = '0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [70:0] pp = '0;

  // Compare process: every cycle, R channel, MEM AR and SRAM writes against the model.
  initial begin
    logic [70:0] cur, e;
    forever begin
      @(negedge clk);
      cur = {bus.inct_rid_o, bus.inct_rdata_o, bus.inct_rresp_o, bus.inct_rlast_o};
      if (pv && !pr && !rst) begin
        chk("r_hold_valid", bus.inct_rvalid_o, 1'b1);
        chk("r_hold_payload", cur, pp);
      end
      if (bus.inct_rvalid_o && !pv) rv_rise = cyc + 1;
      if (bus.inct_rvalid_o && bus.inct_rready_i) begin
        if (exp_q.size() == 0) chk("unexpected_beat", cur, '0);
        else begin
          e = exp_q.pop_front();
          chk("r_beat", cur, e);
          beats_tot++;
        end
      end
      if (bus.mem_arvalid_o && bus.mem_arready_i) begin
        ar_cnt++;
        last_ar = bus.mem_araddr_o;
        chk("mem_ar", {bus.mem_araddr_o, bus.mem_arlen_o, bus.mem_arsize_o, bus.mem_arburst_o, bus.mem_arid_o},
            {exp_line, 4'd7, 3'd3, 2'd1, 4'd0});
      end
      if (bus.wren_o) begin
        wr_cnt++;
        last_waddr = bus.waddr_o;
        last_wtag  = bus.wdata_tag_o;
        chk("sram_wr", {bus.waddr_o, bus.wdata_tag_o}, {exp_idx, 1'b1, exp_tag});
        chk("sram_line", bus.wdata_data_o, line_of(exp_line));
      end
      pv = bus.inct_rvalid_o;
      pr = bus.inct_rready_i;
      pp = cur;
    end
  end

  // Memory slave: random AR accept delay and beat gaps; gives up a burst if rready never comes.
  initial begin
    logic [31:0] base;
    int n;
    bit ok;
    bus.mem_arready_i = 1'b0;
    bus.mem_rvalid_i  = 1'b0;
    bus.mem_rdata_i   = '0;
    bus.mem_rlast_i   = 1'b0;
    bus.mem_rid_i     = '0;
    bus.mem_rresp_i   = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_arvalid_o) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        bus.mem_arready_i = 1'b1;
        base = bus.mem_araddr_o;
        @(posedge clk); #1;
        bus.mem_arready_i = 1'b0;
        ok = 1'b1;
        for (int b = 0; b < 8 && ok; b++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = mw(base + 32'(8 * b));
          bus.mem_rlast_i  = (b == 7);
          bus.mem_rid_i    = 4'($urandom);
          bus.mem_rresp_i  = 2'($urandom);
          n = 0;
          do begin @(negedge clk); n++; end while (!bus.mem_rready_o && n < 30);
          if (!bus.mem_rready_o) ok = 1'b0;
          @(posedge clk); #1;
          bus.mem_rvalid_i = 1'b0;
          bus.mem_rlast_i  = 1'b0;
        end
      end
    end
  end

  task automatic apb_rd(input logic [11:0] a, input logic [31:0] e, input string nm);
    @(posedge clk); #1;
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0; bus.paddr_i = a;
    @(posedge clk); #1;
    bus.penable_i = 1'b1;
    @(negedge clk);
    chk(nm, {bus.pready_o, bus.pslverr_o, bus.prdata_o}, {2'b10, e});
    @(posedge clk); #1;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0;
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b1; bus.paddr_i = a; bus.pwdata_i = d;
    @(posedge clk); #1;
    bus.penable_i = 1'b1;
    @(posedge clk); #1;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
  endtask

  // One INCT read; stall_at >= 0 holds rready low 5 cycles after that many beats.
  task automatic do_read(input logic [31:0] a, input logic [3:0] id, input int stall_at, input bit rnd_rdy);
    int ar0, wr0, b0, n, stalls, hs_edge, w;
    bit miss;
    logic [8:0]  ix;
    logic [16:0] tg;
    logic [31:0] lb;
    ix = a[14:6];
    tg = a[31:15];
    lb = {a[31:6], 6'b0};
    miss = !(ref_v[ix] && ref_tag[ix] == tg);
    exp_line = lb; exp_idx = ix; exp_tag = tg;
    ar0 = ar_cnt; wr0 = wr_cnt; b0 = beats_tot;
    @(posedge clk); #1;
    bus.inct_arvalid_i = 1'b1;
    bus.inct_araddr_i  = a;
    bus.inct_arid_i    = id;
    bus.inct_arlen_i   = 4'($urandom);
    bus.inct_arsize_i  = 3'($urandom);
    bus.inct_arburst_i = 2'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.inct_arready_o && n < 20);
    chk("ar_accept", bus.inct_arready_o, 1'b1);
    hs_edge = cyc + 1;
    for (int j = 0; j < 8; j++) begin
      w = (int'(a[5:3]) + j) % 8;
      exp_q.push_back({id, mw(lb + 32'(8 * w)), 2'b00, j == 7});
    end
    @(posedge clk); #1;
    bus.inct_arvalid_i = 1'b0;
    bus.inct_araddr_i  = $urandom;
    bus.inct_arid_i    = 4'($urandom);
    n = 0; stalls = 0;
    while (beats_tot - b0 < 8 && n < 300) begin
      if (stall_at >= 0 && beats_tot - b0 == stall_at && stalls < 5) begin
        bus.inct_rready_i = 1'b0;
        stalls++;
      end else if (rnd_rdy) bus.inct_rready_i = ($urandom_range(0, 3) != 0);
      else bus.inct_rready_i = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    bus.inct_rready_i = 1'b1;
    chk("beats", beats_tot - b0, 8);
    chk("exp_q_drained", exp_q.size(), 0);
    exp_q.delete();
    chk("mem_ar_count", ar_cnt - ar0, miss ? 1 : 0);
    chk("sram_wr_count", wr_cnt - wr0, miss ? 1 : 0);
    if (!miss) chk("hit_latency", rv_rise - hs_edge, 3);
    if (stall_at >= 0) chk("stall_cycles", stalls, 5);
    ref_v[ix] = 1'b1;
    ref_tag[ix] = tg;
    if (miss) m_miss++; else m_hit++;
  endtask

  initial begin
    logic [31:0] a;
    int ar0, wr0, n;
    int tg, ix, off;
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.paddr_i = '0; bus.pwrite_i = 1'b0; bus.pwdata_i = '0;
    bus.inct_arid_i = '0; bus.inct_araddr_i = '0; bus.inct_arlen_i = '0; bus.inct_arsize_i = '0;
    bus.inct_arburst_i = '0; bus.inct_arvalid_i = 1'b1; bus.inct_rready_i = 1'b1;
    for (int i = 0; i < 512; i++) begin ref_v[i] = 1'b0; ref_tag[i] = '0; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {bus.inct_arready_o, bus.inct_rvalid_o, bus.inct_rlast_o, bus.mem_arvalid_o,
                     bus.mem_rready_o, bus.rden_o, bus.wren_o}, '0);
    chk("rst_data", {bus.inct_rdata_o, bus.inct_rid_o, bus.mem_araddr_o, bus.raddr_o, bus.waddr_o,
                     bus.wdata_tag_o, bus.prdata_o}, '0);
    @(posedge clk); #1;
    rst = 1'b0; sram_rst = 1'b0;
    bus.psel_i = 1'b0; bus.inct_arvalid_i = 1'b0;

    apb_rd(12'h000, 32'h0000_0000, "version");
    apb_rd(12'h010, 32'h0, "unmapped_rd");
    apb_wr(12'h000, 32'hFFFF_FFFF);
    apb_rd(12'h000, 32'h0000_0000, "version_after_wr");

    do_read(32'h0000_1240, 4'd5, -1, 1'b0);
    chk("cold_mem_araddr", last_ar, 32'h0000_1240);
    chk("cold_sram_idx", last_waddr, 9'h049);
    chk("cold_sram_tag", last_wtag, 18'h20000);
    do_read(32'h0000_1258, 4'd9, -1, 1'b0);
    do_read(32'h0000_9240, 4'd3, -1, 1'b0);
    chk("conflict_sram_tag", last_wtag, 18'h20001);
    chk("conflict_sram_idx", last_waddr, 9'h049);
    ar0 = ar_cnt;
    do_read(32'h0000_1240, 4'd7, -1, 1'b0);
    chk("remiss_ar", ar_cnt - ar0, 1);
    apb_rd(12'h004, PERF ? 32'd1 : 32'd0, "perf_hits");
    apb_rd(12'h008, PERF ? 32'd3 : 32'd0, "perf_misses");
    apb_wr(12'h004, 32'h0);
    m_hit = 0; m_miss = 0;
    apb_rd(12'h004, 32'd0, "perf_hits_clr");
    apb_rd(12'h008, 32'd0, "perf_misses_clr");

    do_read(32'h0000_1248, 4'd2, 3, 1'b0);

    // Reset in the middle of a refill: no SRAM write may follow, controller must recover.
    a = 32'hF800_0A00;
    exp_line = {a[31:6], 6'b0}; exp_idx = a[14:6]; exp_tag = a[31:15];
    wr0 = wr_cnt;
    @(posedge clk); #1;
    bus.inct_arvalid_i = 1'b1; bus.inct_araddr_i = a; bus.inct_arid_i = 4'd1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.inct_arready_o && n < 20);
    @(posedge clk); #1;
    bus.inct_arvalid_i = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.mem_rready_o && n < 40);
    chk("midrst_in_refill", bus.mem_rready_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outs", {bus.inct_arready_o, bus.inct_rvalid_o, bus.mem_arvalid_o, bus.mem_rready_o,
                        bus.rden_o, bus.wren_o}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_hit = 0; m_miss = 0;
    repeat (60) @(posedge clk);
    #1;
    chk("midrst_no_wr", wr_cnt - wr0, 0);
    chk("midrst_idle", bus.inct_arready_o, 1'b1);
    do_read(a, 4'd6, -1, 1'b1);

    for (int t = 0; t < 40; t++) begin
      tg  = $urandom_range(0, 2);
      ix  = $urandom_range(0, 3);
      if (ix == 0) ix = 9'h049;
      off = $urandom_range(0, 63);
      a = (32'(tg) << 15) | (32'(ix) << 6) | 32'(off);
      do_read(a, 4'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1, 1'b1);
    end
    apb_rd(12'h004, PERF ? 32'(m_hit) : 32'd0, "perf_hits_final");
    apb_rd(12'h008, PERF ? 32'(m_miss) : 32'd0, "perf_misses_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cc_top_ctrl.md
CC_TOP_CTRL -- requirements
Module: cc_top_ctrl

Interface
REQ-001 SHALL have parameter IP_VER, default 12'h000, value returned by the version register.
REQ-002 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous active-high reset.
REQ-004 SHALL have APB slave ports: psel_i in 1, penable_i in 1, paddr_i in 12, pwrite_i in 1, pwdata_i in 32, pready_o out 1, prdata_o out 32, pslverr_o out 1.
REQ-005 SHALL have INCT AR slave ports: inct_arid_i in 4, inct_araddr_i in 32, inct_arlen_i in 4, inct_arsize_i in 3, inct_arburst_i in 2, inct_arvalid_i in 1, inct_arready_o out 1.
REQ-006 SHALL have INCT R master ports: inct_rid_o out 4, inct_rdata_o out 64, inct_rresp_o out 2, inct_rlast_o out 1, inct_rvalid_o out 1, inct_rready_i in 1.
REQ-007 SHALL have MEM AR master ports: mem_arid_o out 4, mem_araddr_o out 32, mem_arlen_o out 4, mem_arsize_o out 3, mem_arburst_o out 2, mem_arvalid_o out 1, mem_arready_i in 1.
REQ-008 SHALL have MEM R slave ports: mem_rid_i in 4, mem_rdata_i in 64, mem_rresp_i in 2, mem_rlast_i in 1, mem_rvalid_i in 1, mem_rready_o out 1.
REQ-009 SHALL have SRAM ports: rden_o out 1, raddr_o out 9, rdata_tag_i in 18, rdata_data_i in 512, wren_o out 1, waddr_o out 9, wdata_tag_o out 18, wdata_data_o out 512.

Function
REQ-010 SHALL implement a direct-mapped read-only cache: 512 lines x 64 B; tag=araddr[31:15] (17b), index=araddr[14:6], offset=araddr[5:0].
REQ-011 SHALL store tag entry as {valid, tag17}; hit = rdata_tag_i[17] & (rdata_tag_i[16:0]==tag); byte-offset 8k of a line lives in data bits [64k+63:64k].
REQ-012 SHALL accept one request at a time: inct_arready_o=1 only in IDLE; handshake on arvalid&arready captures arid and araddr; arlen/arsize/arburst ignored (always 8 beats x 8 B, WRAP).
REQ-013 SHALL sequence IDLE -> TAG_RD (rden_o=1, raddr_o=index) -> TAG_CMP (SRAM data valid one cycle after rden) -> SEND on hit, MISS_AR on miss.
REQ-014 MISS_AR SHALL hold mem_arvalid_o=1 with mem_araddr_o={araddr[31:6],6'b0}, mem_arlen_o=7, mem_arsize_o=3, mem_arburst_o=1 (INCR), mem_arid_o=0 until mem_arready_i, then enter MISS_R.
REQ-015 MISS_R SHALL drive mem_rready_o=1, store beat i into line word i; on beat with mem_rlast_i go to FILL.
REQ-016 FILL SHALL pulse wren_o one cycle with waddr_o=index, wdata_tag_o={1'b1,tag}, wdata_data_o=assembled line, then enter SEND from the line buffer.
REQ-017 SEND SHALL emit 8 beats, beat j = word ((araddr[5:3]+j) mod 8) (critical word first, wrap); inct_rid_o=captured id, inct_rresp_o=0, inct_rlast_o=1 on beat 7 only.
REQ-018 inct_rvalid_o and payload SHALL stay stable until inct_rready_i; beat advances only on rvalid&rready; after the last handshake return to IDLE.
REQ-019 Hit latency SHALL be: first rvalid 3 cycles after AR handshake (TAG_RD, TAG_CMP, SEND).
REQ-020 mem_rresp_i/mem_rid_i SHALL be ignored; rresp always OKAY.
REQ-021 APB SHALL be zero-wait: pready_o=1, pslverr_o=0; read of paddr 0x000 returns {20'h0,IP_VER}; other unmapped reads return 0; writes have no effect.

Reset
REQ-022 On rst: state IDLE, inct_arready_o=0 during reset, inct_rvalid_o=0, inct_rlast_o=0, mem_arvalid_o=0, mem_rready_o=0, rden_o=0, wren_o=0, prdata_o=0, all data/address outputs 0.
REQ-023 Valid bits SHALL be cleared by the SRAM's own reset; rst mid-transaction SHALL abort the transaction with no further SRAM write.

Configuration
REQ-024 Macro CC_PERF_CNT_EN: when defined, 32-bit wrapping hit and miss counters SHALL be readable at APB 0x004 (hits) and 0x008 (misses), cleared by reset and by any APB write to 0x004; when undefined, both addresses read 0 and no counter logic exists.

Verification
REQ-025 After reset, APB read 0x000 -> prdata 0x00000000 (IP_VER default).
REQ-026 Cold read araddr 0x0000_1240 -> one MEM AR at 0x0000_1240 len 7 INCR, one SRAM write index 0x049 tag {1,17'h0}, 8 beats words 0..7, rlast on beat 8.
REQ-027 Repeat read 0x0000_1258 -> no MEM AR, beats words 3,4,5,6,7,0,1,2 matching memory, first rvalid 3 cycles after AR.
REQ-028 Conflicting read 0x0000_9240 (same index, tag 1) -> miss, refill overwrites tag; next read 0x0000_1240 misses again.
REQ-029 inct_rready_i held low 5 cycles mid-burst -> rvalid/rdata/rlast remain stable, no beat lost.
REQ-030 With CC_PERF_CNT_EN, after scenarios 026-028 -> 0x004 reads 1, 0x008 reads 3.
